// File: rtl/multiplexer_n_2to1.sv
// N-bit 2:1 bus multiplexer built from per-bit gate-level muxes, plus a registered copy.
// Optional MUX_PARITY_EN adds parity_q, the registered even parity of channel_out.

module multiplexer_2to1_bit (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  logic sel_n;
  logic a_term;
  logic b_term;

  not u_not (sel_n, sel);
  and u_and_a (a_term, a, sel_n);
  and u_and_b (b_term, b, sel);
  or  u_or (y, a_term, b_term);

endmodule

module multiplexer_n_2to1 #(
  parameter int unsigned N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic         select,
  output logic [N-1:0] channel_out,
  output logic [N-1:0] channel_out_q,
  output logic         select_q
`ifdef MUX_PARITY_EN
  ,
  output logic         parity_q
`endif
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    multiplexer_2to1_bit u_bit (
      .a  (in0[i]),
      .b  (in1[i]),
      .sel(select),
      .y  (channel_out[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      channel_out_q <= '0;
      select_q      <= 1'b0;
    end else begin
      channel_out_q <= channel_out;
      select_q      <= select;
    end
  end

`ifdef MUX_PARITY_EN
  logic parity_d;

  always_comb begin
    parity_d = ^channel_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_multiplexer_n_2to1.sv
// Self-checking bench for multiplexer_n_2to1: per-cycle model compare plus directed literal checks.
`timescale 1ns/1ps

module tb_multiplexer_n_2to1;

  localparam int unsigned N = 10;

  logic         clk;
  logic         rst;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic         select;
  logic [N-1:0] channel_out;
  logic [N-1:0] channel_out_q;
  logic         select_q;
`ifdef MUX_PARITY_EN
  logic         parity_q;
`endif

  int tests;
  int fails;

  multiplexer_n_2to1 #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in0          (in0),
    .in1          (in1),
    .select       (select),
    .channel_out  (channel_out),
    .channel_out_q(channel_out_q),
    .select_q     (select_q)
`ifdef MUX_PARITY_EN
    ,
    .parity_q     (parity_q)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pick a channel, count parity, delay one cycle.
  logic [N-1:0] m_q;
  logic         m_sel;
  logic         m_par;
  logic         m_valid;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q   <= '0;
      m_sel <= 1'b0;
      m_par <= 1'b0;
    end else begin
      m_q   <= select ? in1 : in0;
      m_sel <= select;
      m_par <= ($countones(select ? in1 : in0) % 2) == 1;
    end
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_comb;
    exp_comb = select ? in1 : in0;
    tests++;
    if (channel_out !== exp_comb) begin
      fails++;
      $display("FAIL model_comb: got %b expected %b", channel_out, exp_comb);
    end
    if (m_valid) begin
      tests++;
      if (channel_out_q !== m_q) begin
        fails++;
        $display("FAIL model_q: got %b expected %b", channel_out_q, m_q);
      end
      tests++;
      if (select_q !== m_sel) begin
        fails++;
        $display("FAIL model_select_q: got %b expected %b", select_q, m_sel);
      end
`ifdef MUX_PARITY_EN
      tests++;
      if (parity_q !== m_par) begin
        fails++;
        $display("FAIL model_parity_q: got %b expected %b", parity_q, m_par);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] w;
    rst    = 1'b1;
    in0    = '0;
    in1    = '0;
    select = 1'b0;
    step();
    chk("reset_q", channel_out_q, '0);
    chk("reset_select_q", N'(select_q), '0);

    // Vector 1: select in0
    rst = 1'b0;
    in0 = 10'b1001110011;
    in1 = 10'b0110001100;
    select = 1'b0;
    #1;
    chk("v1_comb", channel_out, 10'b1001110011);
    step();
    chk("v1_q", channel_out_q, 10'b1001110011);
    chk("v1_select_q", N'(select_q), N'(0));

    // Vector 2: select in1
    in0 = 10'b1111111111;
    in1 = 10'b0000100001;
    select = 1'b1;
    #1;
    chk("v2_comb", channel_out, 10'b0000100001);
    step();
    chk("v2_q", channel_out_q, 10'b0000100001);
    chk("v2_select_q", N'(select_q), N'(1));
`ifdef MUX_PARITY_EN
    chk("v2_parity_q", N'(parity_q), N'(0));
`endif

    // Mid-stream reset clears only the registered stage
    in1 = 10'b1010101010;
    select = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_comb_before", channel_out, 10'b1010101010);
    step();
    chk("rst_q", channel_out_q, 10'b0000000000);
    chk("rst_select_q", N'(select_q), N'(0));
    chk("rst_comb_during", channel_out, 10'b1010101010);
    rst = 1'b0;
    step();
    chk("post_rst_q", channel_out_q, 10'b1010101010);
    chk("post_rst_select_q", N'(select_q), N'(1));

    // Equal inputs: select irrelevant
    in0 = 10'b0101010101;
    in1 = 10'b0101010101;
    for (int i = 0; i < 6; i++) begin
      select = i[0];
      step();
      chk("eq_comb", channel_out, 10'b0101010101);
      chk("eq_q", channel_out_q, 10'b0101010101);
    end

    // Walking one on in1 then in0
    in0 = '0;
    select = 1'b1;
    for (int i = 0; i < N; i++) begin
      w = '0;
      w[i] = 1'b1;
      in1 = w;
      #1;
      chk("walk_in1", channel_out, N'(1) << i);
    end
    in1 = '0;
    select = 1'b0;
    for (int i = 0; i < N; i++) begin
      w = '0;
      w[i] = 1'b1;
      in0 = w;
      #1;
      chk("walk_in0", channel_out, N'(1) << i);
    end
    step();

    // Alternating select: registered output lags by exactly one cycle
    in0 = 10'b0000000000;
    in1 = 10'b1111111111;
    for (int i = 0; i < 8; i++) begin
      select = i[0];
      #1;
      chk("alt_comb", channel_out, i[0] ? 10'b1111111111 : 10'b0000000000);
      step();
      chk("alt_q", channel_out_q, i[0] ? 10'b1111111111 : 10'b0000000000);
      chk("alt_select_q", N'(select_q), N'(i[0]));
    end

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
